// File: rtl/rr_mux_pkg.sv
// Shared types and default sizes for the rr_mux_n channel multiplexer.
package rr_mux_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_N     = 4;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } out_state_e;

    // Single-register build calls the one-entry state FULL
    localparam out_state_e ST_FULL = ST_ONE;

endpackage

// File: rtl/rr_mux_n_arbiter.sv
// Combinational rotating-priority arbiter: first request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_any
);

    localparam int unsigned IW = $clog2(N);

    int unsigned idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!grant_any && req[IW'(idx)]) begin
                grant_any          = 1'b1;
                grant[IW'(idx)]    = 1'b1;
                grant_idx          = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_mux_n.sv
// N-channel valid/ready mux with explicit-select or round-robin arbitration and a
// registered output; define RR_MUX_SKID_EN for a two-entry output with a skid slot.
module rr_mux_n
    import rr_mux_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned N     = DEF_N
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 mode,
    input  logic [$clog2(N)-1:0] sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [$clog2(N)-1:0] out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int unsigned IW = $clog2(N);

    out_state_e       state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] head_data_q, head_data_d;
    logic [IW-1:0]    head_ch_q, head_ch_d;
`ifdef RR_MUX_SKID_EN
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [IW-1:0]    skid_ch_q, skid_ch_d;
`endif

    logic [N-1:0]     req;
    logic [N-1:0]     grant;
    logic [IW-1:0]    grant_idx;
    logic             grant_any;
    logic             can_accept;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_data;

    // Eligible requesters: all valids in round-robin, only a legal sel otherwise
    always_comb begin
        req = '0;
        if (mode_e'(mode) == MODE_RR) begin
            req = in_valid;
        end else if (32'(sel) < N) begin
            req[sel] = in_valid[sel];
        end
    end

    rr_arbiter #(.N(N)) u_arb (
        .req       (req),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = head_data_q;
    assign out_ch    = head_ch_q;
    assign pop       = out_valid && out_ready;

`ifdef RR_MUX_SKID_EN
    assign can_accept = (state_q != ST_TWO);
`else
    assign can_accept = !out_valid || out_ready;
`endif

    assign in_ready  = (rst_n && can_accept) ? grant : '0;
    assign push      = rst_n && can_accept && grant_any;
    assign push_data = in_data[32'(grant_idx)*WIDTH +: WIDTH];

    // Pointer advances past the winner only on a round-robin transfer
    always_comb begin
        ptr_d = ptr_q;
        if (push && mode_e'(mode) == MODE_RR) begin
            ptr_d = (32'(grant_idx) == N - 1) ? '0 : grant_idx + IW'(1);
        end
    end

    // Output occupancy and data movement
    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_ch_d   = head_ch_q;
`ifdef RR_MUX_SKID_EN
        skid_data_d = skid_data_q;
        skid_ch_d   = skid_ch_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d     = ST_ONE;
                    head_data_d = push_data;
                    head_ch_d   = grant_idx;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    head_data_d = push_data;
                    head_ch_d   = grant_idx;
                end else if (push) begin
                    state_d     = ST_TWO;
                    skid_data_d = push_data;
                    skid_ch_d   = grant_idx;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            default: begin
                if (pop) begin
                    state_d     = ST_ONE;
                    head_data_d = skid_data_q;
                    head_ch_d   = skid_ch_q;
                end
            end
        endcase
`else
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d     = ST_FULL;
                    head_data_d = push_data;
                    head_ch_d   = grant_idx;
                end
            end
            default: begin
                if (push) begin
                    head_data_d = push_data;
                    head_ch_d   = grant_idx;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
        endcase
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            ptr_q       <= '0;
            head_data_q <= '0;
            head_ch_q   <= '0;
`ifdef RR_MUX_SKID_EN
            skid_data_q <= '0;
            skid_ch_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            head_data_q <= head_data_d;
            head_ch_q   <= head_ch_d;
`ifdef RR_MUX_SKID_EN
            skid_data_q <= skid_data_d;
            skid_ch_q   <= skid_ch_d;
`endif
        end
    end

endmodule
